// File: rtl/alu_issue_queue.sv
// alu_issue_queue: small request FIFO feeding a combinational ALU,
// with a registered, handshaked result stage tagged by select and error.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [2:0]       in_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_sel,
  output logic             res_err,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [18:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [2:0]       res_sel_q, res_sel_d;
  logic             res_err_q, res_err_d;

  logic        empty;
  logic        push;
  logic        pop;
  logic        div0;
  logic [18:0] head;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!res_valid_q || res_ready);
  assign head     = mem_q[rd_ptr_q];
  assign div0     = (alu_sel == 3'b111) && (alu_b == 8'h00);

  assign count     = count_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_sel   = res_sel_q;
  assign res_err   = res_err_q;

  // Head entry drives the ALU; zeros when nothing is queued.
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_sel = 3'b000;
    if (!empty) begin
      alu_a   = head[7:0];
      alu_b   = head[15:8];
      alu_sel = head[18:16];
    end
  end

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_sel, in_b, in_a};
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Result register: load on pop, clear valid when consumed alone.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    res_err_d   = res_err_q;
    if (pop) begin
      res_valid_d = 1'b1;
      res_sel_d   = alu_sel;
      res_data_d  = div0 ? 8'hFF : alu_out;
      res_err_d   = div0;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_sel_q   <= 3'b000;
      res_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scenario tasks plus randomized traffic
// checked against a queue-based cycle model of the issue queue.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;

  logic       clk, rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_sel;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] res_sel;
  logic       res_err;
  logic [2:0] count;

  int n_cmp = 0;
  int n_fail = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sel(res_sel),
    .res_err(res_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for alu8bit.
  function automatic logic [7:0] alu_fn(
    input logic [7:0] a, input logic [7:0] b,
    input logic [2:0] s);
    case (s)
      3'd0: alu_fn = a - b;
      3'd1: alu_fn = a + b;
      3'd2: alu_fn = a & b;
      3'd3: alu_fn = a >> 1;
      3'd4: alu_fn = a << 1;
      3'd5: alu_fn = a | b;
      3'd6: alu_fn = a ^ b;
      default: alu_fn = (b == 0) ? 8'h5A : a / b;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_a, alu_b, alu_sel);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
  } req_t;

  req_t       mq[$];
  logic       m_rv;
  logic [7:0] m_data;
  logic [2:0] m_sel;
  logic       m_err;
  int         m_pops;

  task automatic model_clear();
    mq.delete();
    m_rv = 0; m_data = 0; m_sel = 0; m_err = 0;
  endtask

  // One clock edge: advance the model with the inputs seen there.
  task automatic cycle();
    bit   do_push, do_pop;
    req_t r, h;
    @(posedge clk);
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && (!m_rv || res_ready);
    r.a = in_a; r.b = in_b; r.sel = in_sel;
    if (do_pop) begin
      h = mq.pop_front();
      m_rv  = 1;
      m_sel = h.sel;
      m_err = (h.sel == 3'b111) && (h.b == 0);
      m_data = m_err ? 8'hFF : alu_fn(h.a, h.b, h.sel);
      m_pops++;
    end else if (m_rv && res_ready) begin
      m_rv = 0;
    end
    if (do_push) mq.push_back(r);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] s,
                       input logic rr);
    in_valid = v; in_a = a; in_b = b; in_sel = s;
    res_ready = rr;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 0, 0, 0);
    model_clear();
    #2;
    n_cmp++;
    if (count !== 3'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++;
    if ({res_valid, res_data, res_sel, res_err} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_result: got v%b d%h s%h e%b want 0",
               res_valid, res_data, res_sel, res_err); end
    n_cmp++;
    if ({alu_a, alu_b, alu_sel} !== 19'h0) begin n_fail++;
      $display("FAIL reset_alu: got %h %h %h want 0",
               alu_a, alu_b, alu_sel); end
    #10 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    drive(1, 8'h0A, 8'h03, 3'b000, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    n_cmp++;
    if (res_valid !== 1'b0 || count !== 3'd1) begin n_fail++;
      $display("FAIL basic_accept: got v%b c%0d want v0 c1",
               res_valid, count); end
    n_cmp++;
    if (alu_a !== 8'h0A || alu_b !== 8'h03) begin n_fail++;
      $display("FAIL basic_alu: got %h %h want 0a 03",
               alu_a, alu_b); end
    cycle();
    n_cmp++;
    if ({res_valid, res_data, res_sel, res_err} !==
        {1'b1, 8'h07, 3'b000, 1'b0}) begin n_fail++;
      $display("FAIL basic_result: got v%b d%h s%h e%b want 1 07 0 0",
               res_valid, res_data, res_sel, res_err); end
    cycle();
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 8'h07) begin n_fail++;
      $display("FAIL basic_consume: got v%b d%h want v0 d07",
               res_valid, res_data); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h10 + 8'(i), 8'h01, 3'b001, 0);
      cycle();
    end
    n_cmp++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL stall_count3: got c%0d r%b want c3 r1",
               count, in_ready); end
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 8'h11) begin n_fail++;
      $display("FAIL stall_held: got v%b d%h want v1 d11",
               res_valid, res_data); end
    drive(1, 8'h20, 8'h02, 3'b001, 0);
    cycle();
    n_cmp++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL stall_full: got c%0d r%b want c4 r0",
               count, in_ready); end
    drive(1, 8'h30, 8'h03, 3'b001, 0);
    cycle();
    n_cmp++;
    if (count !== 3'd4 || res_data !== 8'h11) begin n_fail++;
      $display("FAIL stall_refuse: got c%0d d%h want c4 d11",
               count, res_data); end
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_cmp++;
      if (res_valid !== m_rv || count !== 3'(mq.size()) ||
          (m_rv && res_data !== m_data)) begin n_fail++;
        $display("FAIL stall_drain%0d: got v%b c%0d d%h want v%b c%0d d%h",
                 i, res_valid, count, res_data,
                 m_rv, mq.size(), m_data); end
    end
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 8'h22) begin n_fail++;
      $display("FAIL stall_last: got v%b d%h want v0 d22",
               res_valid, res_data); end
  endtask

  task automatic test_div();
    drive(1, 8'h20, 8'h00, 3'b111, 1);
    cycle();
    drive(1, 8'h20, 8'h04, 3'b111, 1);
    cycle();
    n_cmp++;
    if ({res_valid, res_data, res_sel, res_err} !==
        {1'b1, 8'hFF, 3'b111, 1'b1}) begin n_fail++;
      $display("FAIL div_zero: got v%b d%h s%h e%b want 1 ff 7 1",
               res_valid, res_data, res_sel, res_err); end
    drive(0, 0, 0, 0, 1);
    cycle();
    n_cmp++;
    if ({res_valid, res_data, res_sel, res_err} !==
        {1'b1, 8'h08, 3'b111, 1'b0}) begin n_fail++;
      $display("FAIL div_ok: got v%b d%h s%h e%b want 1 08 7 0",
               res_valid, res_data, res_sel, res_err); end
    cycle();
  endtask

  task automatic test_back_to_back();
    int nres;
    int maxc;
    logic [7:0] exp_d [8];
    for (int s = 0; s < 8; s++)
      exp_d[s] = alu_fn(8'hC3, 8'h05, 3'(s));
    nres = 0;
    maxc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1, 8'hC3, 8'h05, 3'(i), 1);
      else       drive(0, 0, 0, 0, 1);
      cycle();
      if (int'(count) > maxc) maxc = int'(count);
      if (res_valid === 1'b1) begin
        n_cmp++;
        if (nres >= 8 || res_sel !== 3'(nres) ||
            res_data !== exp_d[nres]) begin n_fail++;
          $display("FAIL b2b_res%0d: got s%h d%h want s%h d%h",
                   nres, res_sel, res_data, 3'(nres),
                   exp_d[nres % 8]); end
        nres++;
      end
    end
    n_cmp++;
    if (nres !== 8) begin n_fail++;
      $display("FAIL b2b_count: got %0d results want 8", nres); end
    n_cmp++;
    if (maxc > 1) begin n_fail++;
      $display("FAIL b2b_occupancy: got max %0d want <=1", maxc); end
    n_cmp++;
    if (exp_d[3] !== 8'h61 || exp_d[4] !== 8'h86) begin n_fail++;
      $display("FAIL b2b_alu: got %h %h want 61 86",
               exp_d[3], exp_d[4]); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'h40 + 8'(i), 8'h01, 3'b110, 0);
      cycle();
    end
    drive(1, 8'hEE, 8'hEE, 3'b110, 0);
    cycle();
    n_cmp++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin n_fail++;
      $display("FAIL full_block: got r%b c%0d want r0 c4",
               in_ready, count); end
    drive(0, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL full_pulse: got c%0d r%b want c3 r1",
               count, in_ready); end
    n_cmp++;
    if (res_data !== 8'h40) begin n_fail++;
      $display("FAIL full_next: got d%h want 40", res_data); end
  endtask

  task automatic test_async_reset();
    n_cmp++;
    if (res_valid !== 1'b1 || count !== 3'd3) begin n_fail++;
      $display("FAIL areset_pre: got v%b c%0d want v1 c3",
               res_valid, count); end
    #2 rst = 1;
    model_clear();
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || count !== 3'd0 ||
        in_ready !== 1'b1) begin n_fail++;
      $display("FAIL areset_now: got v%b c%0d r%b want v0 c0 r1",
               res_valid, count, in_ready); end
    #3 rst = 0;
    drive(1, 8'h55, 8'h11, 3'b001, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    cycle();
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 8'h66 ||
        res_sel !== 3'b001) begin n_fail++;
      $display("FAIL areset_first: got v%b d%h s%h want 1 66 1",
               res_valid, res_data, res_sel); end
    cycle();
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 400; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drive(1'($urandom_range(0, 2) != 0), 8'($urandom), b,
            3'($urandom), 1'($urandom_range(0, 2) != 0));
      cycle();
      n_cmp++;
      if (count !== 3'(mq.size()) ||
          in_ready !== (mq.size() < DEPTH) ||
          res_valid !== m_rv) begin n_fail++;
        $display("FAIL rnd_ctl%0d: got c%0d r%b v%b want c%0d r%b v%b",
                 i, count, in_ready, res_valid, mq.size(),
                 mq.size() < DEPTH, m_rv); end
      n_cmp++;
      if (res_data !== m_data || res_sel !== m_sel ||
          res_err !== m_err) begin n_fail++;
        $display("FAIL rnd_res%0d: got d%h s%h e%b want d%h s%h e%b",
                 i, res_data, res_sel, res_err,
                 m_data, m_sel, m_err); end
      if (mq.size() > 0) begin
        n_cmp++;
        if (alu_a !== mq[0].a || alu_b !== mq[0].b ||
            alu_sel !== mq[0].sel) begin n_fail++;
          $display("FAIL rnd_head%0d: got %h %h %h want %h %h %h",
                   i, alu_a, alu_b, alu_sel,
                   mq[0].a, mq[0].b, mq[0].sel); end
      end
    end
  endtask

  initial begin
    m_pops = 0;
    test_reset();
    test_basic();
    test_stall();
    test_div();
    test_back_to_back();
    test_full();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder for the combinational 8-bit ALU (alu8bit); buffers operation requests from a producer in a small FIFO.
- Presents the head entry's operands and select code to the ALU and registers the ALU result.
- Delivers each result downstream over a valid/ready handshake, tagged with its select code and a divide-by-zero error flag.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  producer has a request.
- in_ready  output  1  queue can accept a request.
- in_a  input  8  operand A.
- in_b  input  8  operand B.
- in_sel  input  3  ALU select code.
- alu_a  output  8  operand A to ALU.
- alu_b  output  8  operand B to ALU.
- alu_sel  output  3  select to ALU.
- alu_out  input  8  combinational ALU result.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  8  registered result.
- res_sel  output  3  select code that produced res_data.
- res_err  output  1  result came from divide with in_b==0.
- count  output  PTR_W+1  current FIFO occupancy.

Behaviour:
- Reset: asynchronous, active-high, and forces the following values immediately:
  - FIFO pointers and count = 0.
  - in_ready = 1.
  - res_valid = 0, res_data = 8'h00, res_sel = 3'b000, res_err = 0.
  - Storage contents need not be cleared.
- Push: occurs on a rising edge when in_valid && in_ready. Stores {in_sel, in_b, in_a} at the write pointer; the pointer wraps modulo DEPTH.
- in_ready = (count < DEPTH), decoded from registered count. There is no full-bypass: when full, in_ready = 0 even if a pop happens in the same cycle.
- ALU drive:
  - FIFO non-empty: alu_a/alu_b/alu_sel = head entry, combinational from storage and the read pointer, so stable for the whole cycle.
  - FIFO empty: all three = 0.
- Pop condition: fires when FIFO non-empty && (!res_valid || res_ready). On a pop edge:
  - The read pointer advances, wrapping modulo DEPTH.
  - The result register loads.
  - res_valid = 1.
- Result register load on pop:
  - res_sel = alu_sel.
  - If alu_sel == 3'b111 && alu_b == 0: res_data = 8'hFF, res_err = 1, and alu_out is ignored.
  - Otherwise: res_data = alu_out, res_err = 0.
- Result consumption:
  - res_valid && res_ready with no pop: res_valid goes to 0; res_data/res_sel/res_err hold their values.
  - res_valid && res_ready with a pop in the same cycle: the register reloads with the new result and res_valid stays 1, giving full throughput of one result per cycle.
- Stall: while res_valid && !res_ready, res_data/res_sel/res_err are held stable and there is no pop.
- count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Latency: a request accepted at edge N onto an empty queue with a free result register gives res_valid = 1 after edge N+1. Minimum latency is 2 clocks; steady-state throughput is 1 per clock.
- Ordering: results leave strictly in acceptance order. Nothing is dropped or duplicated.
- Reset mid-operation: queued entries and any pending result are discarded. The first post-reset push is treated as entry 0.

Test Plan:
- Reset, then push {a=8'h0A, b=8'h03, sel=000}, res_ready=1 -> res_valid rises 2 cycles after accept; res_data=8'h07, res_sel=000, res_err=0.
- Push 4 ops with res_ready=0 -> first result is held; remaining 3 stay queued. Push 2 more ops -> count=3, in_ready=1, first push accepted, count=4, in_ready=0. Raise res_ready -> results drain in order, one per cycle.
- Push {a=8'h20, b=8'h00, sel=111} -> res_data=8'hFF, res_err=1. Then push {a=8'h20, b=8'h04, sel=111} -> res_data=8'h08, res_err=0.
- Continuous push with res_ready=1 for 8 ops (sel 000..111, a=8'hC3, b=8'h05) -> 8 results back-to-back, each matching the ALU function (e.g. sel 011 -> 8'h61, sel 100 -> 8'h86); count never exceeds 1.
- Queue full and res_ready=0; assert in_valid -> in_ready=0 and no write occurs. Pulse res_ready for one cycle -> count drops to 3, then in_ready rises.
- Assert rst asynchronously between clock edges with 3 entries queued and res_valid=1 -> res_valid=0, count=0, in_ready=1 immediately; next push is returned as the first result.
